// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcode encodings and condition-flag class decode.
// Pure declarations, no timing.
// Used by alu_wb to decide which flags an accepted result updates.
package cpu_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_RED    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LLB    = 4'h8;
  localparam logic [3:0] OP_LHB    = 4'h9;

  // Which condition flags an opcode is allowed to write.
  typedef enum logic [1:0] {
    FC_NONE = 2'd0,  // all flags held
    FC_Z    = 2'd1,  // zero flag only
    FC_ZVN  = 2'd2   // zero, overflow and negative
  } flag_class_t;

  function automatic flag_class_t flag_class(input logic [3:0] op);
    flag_class_t fc;
    fc = FC_NONE;
    case (op)
      OP_ADD, OP_SUB:                 fc = FC_ZVN;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: fc = FC_Z;
      default:                        fc = FC_NONE;
    endcase
    return fc;
  endfunction

endpackage

// File: rtl/wb_skid.sv
// Writeback entry buffer: one register (DEPTH=1) or a two-entry skid buffer (DEPTH=2).
// Latency: an entry pushed into an empty buffer is on out_dat/out_valid one cycle later.
// Backpressure: DEPTH=2 ready depends only on occupancy; DEPTH=1 ready passes out_ready through.
module wb_skid #(
  parameter int W     = 21,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  output logic         ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_dat
);

  logic [1:0]   count;
  logic [W-1:0] slot1;
  logic         pop;

  // Head entry lives directly in out_dat so outputs come straight from flops.
  assign out_valid = (count != 2'd0);
  // A flush cycle never retires the head, even if downstream asserted ready.
  assign pop       = out_valid && out_ready && !flush;

  if (DEPTH >= 2) begin : g_skid
    // Decision uses only registered occupancy, breaking the ready path.
    assign ready = (count != 2'd2);
  end else begin : g_reg
    // Single register can refill in the same cycle it drains.
    assign ready = !out_valid || out_ready;
  end

  // Occupancy and storage update; second slot shifts to head on pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= 2'd0;
      out_dat <= '0;
      slot1   <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) out_dat <= push_dat;
          else               slot1   <= push_dat;
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) out_dat <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd2) begin
            out_dat <= slot1;
            slot1   <= push_dat;
          end else begin
            out_dat <= push_dat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_wb.sv
// ALU writeback stage: buffers results for the register file and maintains Z/V/N flags.
// Latency 1 from acceptance to out_valid; flags update on the edge that accepts a result.
// in_ready drops on flush, in reset, or when the buffer is full; ALU_WB_SKID_EN selects a 2-deep skid buffer.
module alu_wb
  import cpu_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_aluop,
  input  logic [DATA_W-1:0]  in_aluout,
  input  logic               in_err,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic               in_wb_en,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [RADDR_W-1:0] out_rd,
  output logic               out_wb_en,
  output logic               flag_z,
  output logic               flag_v,
  output logic               flag_n
);

`ifdef ALU_WB_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  localparam int EW = DATA_W + RADDR_W + 1;

  logic          buf_ready;
  logic          accept;
  logic [EW-1:0] head;
  flag_class_t   fc;

  // Reset gating makes in_ready low for the whole reset pulse, not only after the first edge.
  assign in_ready = rst_n && !flush && buf_ready;
  assign accept   = in_valid && in_ready;
  assign fc       = flag_class(in_aluop);

  wb_skid #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (accept),
    .push_dat  ({in_aluout, in_rd, in_wb_en}),
    .ready     (buf_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_dat   (head)
  );

  assign {out_data, out_rd, out_wb_en} = head;

  // Flags follow accepted ops, regardless of when the register file retires them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z <= 1'b0;
      flag_v <= 1'b0;
      flag_n <= 1'b0;
    end else if (accept) begin
      if (fc != FC_NONE) flag_z <= (in_aluout == '0);
      if (fc == FC_ZVN) begin
        flag_v <= in_err;
        flag_n <= in_aluout[DATA_W-1];
      end
    end
  end

endmodule

// File: doc/alu_wb.md
ALU_WB -- requirements
Module: alu_wb

Interface
REQ-001 SHALL have parameter DATA_W, default 16, datapath width.
REQ-002 SHALL have parameter RADDR_W, default 4, destination register index width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  ALU result present.
REQ-006 SHALL have port in_ready  output  1  block can accept this cycle.
REQ-007 SHALL have port in_aluop  input  4  opcode that produced the result.
REQ-008 SHALL have port in_aluout  input  DATA_W  ALU result.
REQ-009 SHALL have port in_err  input  1  ALU overflow flag.
REQ-010 SHALL have port in_rd  input  RADDR_W  writeback destination.
REQ-011 SHALL have port in_wb_en  input  1  result is to be written back.
REQ-012 SHALL have port flush  input  1  discard all buffered entries.
REQ-013 SHALL have port out_valid  output  1  writeback entry present.
REQ-014 SHALL have port out_ready  input  1  register file consumes entry.
REQ-015 SHALL have ports out_data / out_rd / out_wb_en  output  DATA_W / RADDR_W / 1  buffered entry fields.
REQ-016 SHALL have ports flag_z, flag_v, flag_n  output  1 each  condition flags.

Function
REQ-017 Transfer in = in_valid && in_ready; transfer out = out_valid && out_ready.
REQ-018 Accepted entry SHALL appear on out_* exactly one cycle after acceptance when buffer was empty (latency 1).
REQ-019 Entries SHALL leave in acceptance order; out_* SHALL hold stable while out_valid && !out_ready.
REQ-020 Flag update on accept, registered next edge: op 0x0/0x1 -> Z=(aluout==0), V=in_err, N=aluout[DATA_W-1]; op 0x2,0x4,0x5,0x6 -> Z only, V/N held; op 0x3,0x7-0xF -> all flags held.
REQ-021 Flag update SHALL be independent of out_ready (flags reflect accepted, not retired, ops).
REQ-022 flush SHALL force in_ready=0 that cycle, and on the next edge clear all buffered entries (out_valid=0); flags unchanged.
REQ-023 Simultaneous flush and out_ready: entry at head not counted as consumed; downstream SHALL ignore out_valid while flush is high.
REQ-024 Simultaneous in/out transfer when one entry held SHALL keep occupancy constant.

Reset
REQ-025 rst_n low SHALL immediately clear: out_valid=0, buffer empty, out_data=0, out_rd=0, out_wb_en=0, flag_z=0, flag_v=0, flag_n=0.
REQ-026 in_ready SHALL be 0 while rst_n low and 1 on first cycle after release.
REQ-027 Reset mid-backpressure SHALL drop all entries; no entry reappears after release.

Configuration
REQ-028 Macro ALU_WB_SKID_EN defined: two-entry skid buffer, in_ready registered = !(occupancy==2), full throughput under intermittent backpressure.
REQ-029 Macro undefined: single entry register, in_ready = !out_valid || out_ready (combinational), all other behaviour identical.

Structure
REQ-030 Opcode localparams (OP_ADD=0x0 .. OP_LHB=0x9) and flag-class decode function SHALL live in shared package cpu_pkg, reused by alu.
REQ-031 Buffer SHALL be a sub-module wb_skid (depth 1 or 2 per macro); flag logic stays in alu_wb.

Verification
REQ-032 op=0, aluout=0x1d52, err=1, out_ready=1 -> next cycle out_data=0x1d52, flag_z=0, flag_v=1, flag_n=0.
REQ-033 op=1, aluout=0x9e38, err=0 -> flag_n=1, flag_v=0, flag_z=0.
REQ-034 After REQ-033, op=2, aluout=0x0000 -> flag_z=1, flag_n=1 and flag_v=0 held; then op=8, aluout=0x1188 -> flags unchanged.
REQ-035 out_ready=0, three back-to-back inputs 0x0001,0x0002,0x0003 -> SKID: two accepted, in_ready=0, third stalled; release -> outputs 0x0001,0x0002,0x0003 in order; no SKID: one accepted.
REQ-036 Two entries buffered, flush=1 one cycle -> out_valid=0 next cycle, flags unchanged, in_ready=0 during flush.
REQ-037 rst_n pulsed low mid-stall with entries buffered -> all outputs and flags 0 immediately, in_ready=1 after release, no stale output.
